hash_target_check: RTL

Downstream stage of the SHA-256 mining pipeline. Consumes each final 256-bit `HASH` produced by the chunk-compression stage, compares it serially against a difficulty target, and drives the nonce search. It requests one hash per nonce, increments the nonce on failure, and stops on a winning nonce or when the try budget is exhausted.

---
 rtl/mining_pkg.sv | 16 +
 rtl/hash_cmp_serial.sv | 59 +++++
 rtl/hash_target_check.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mining_pkg.sv
// Shared types and sizes for the mining pipeline's nonce-search stage.
package mining_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned HASH_W_DFLT = 256;
  localparam int unsigned HASH_WORDS  = HASH_W_DFLT / WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CMP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/hash_cmp_serial.sv
// Serial hash <= target compare, one 32-bit word per cycle, most significant word first.
module hash_cmp_serial
  import mining_pkg::*;
#(
  parameter int unsigned HASH_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tgt_load,
  input  logic [HASH_W-1:0] i_target,
  input  logic              i_load,
  input  logic [HASH_W-1:0] i_hash,
  input  logic              i_step,
  output logic [HASH_W-1:0] o_hash,
  output logic              o_done_c,
  output logic              o_pass_c
);

  localparam int unsigned N_WORDS = HASH_W / WORD_W;
  localparam int unsigned IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic [HASH_W-1:0] r_hash;
  logic [HASH_W-1:0] r_target;
  logic [IDX_W-1:0]  r_idx;

  logic [WORD_W-1:0] w_hash_word;
  logic [WORD_W-1:0] w_tgt_word;
  logic              w_last;

  // Word r_idx counted from the top of the vector.
  always_comb begin
    w_hash_word = WORD_W'(r_hash   >> (WORD_W * (N_WORDS - 1 - 32'(r_idx))));
    w_tgt_word  = WORD_W'(r_target >> (WORD_W * (N_WORDS - 1 - 32'(r_idx))));
    w_last      = (r_idx == IDX_W'(N_WORDS - 1));
    o_done_c    = (w_hash_word != w_tgt_word) || w_last;
    o_pass_c    = (w_hash_word < w_tgt_word) || ((w_hash_word == w_tgt_word) && w_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hash   <= '0;
      r_target <= '0;
      r_idx    <= '0;
    end else begin
      if (i_tgt_load) begin
        r_target <= i_target;
      end
      if (i_load) begin
        r_hash <= i_hash;
        r_idx  <= '0;
      end else if (i_step && !o_done_c) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_hash = r_hash;

endmodule

// File: rtl/hash_target_check.sv
// Nonce search controller: requests one hash per nonce and stops on a hash <= target or on budget exhaustion.
module hash_target_check
  import mining_pkg::*;
#(
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned HASH_W  = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] max_tries,
  input  logic [HASH_W-1:0]  target,
  input  logic               hash_valid,
  input  logic [HASH_W-1:0]  HASH,
  output logic [NONCE_W-1:0] nonce,
  output logic               run_req,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [NONCE_W-1:0] golden_nonce,
  output logic [HASH_W-1:0]  golden_hash,
  output logic [NONCE_W-1:0] tries
);

  state_t r_state;
  state_t w_state_nxt;

  logic [NONCE_W-1:0] r_nonce;
  logic [NONCE_W-1:0] r_tries;
  logic [NONCE_W-1:0] r_max;
  logic [NONCE_W-1:0] r_gnonce;
  logic [HASH_W-1:0]  r_ghash;
  logic               r_found;
  logic               r_exh;
  logic               r_run_req;
  logic               r_busy;

  logic [NONCE_W-1:0] w_nonce_nxt;
  logic [NONCE_W-1:0] w_tries_nxt;
  logic [NONCE_W-1:0] w_tries_inc;
  logic [NONCE_W-1:0] w_gnonce_nxt;
  logic [HASH_W-1:0]  w_ghash_nxt;
  logic               w_found_nxt;
  logic               w_exh_nxt;
  logic               w_accept;
  logic               w_cmp_load;
  logic               w_cmp_step;
  logic [HASH_W-1:0]  w_cap_hash;
  logic               w_cmp_done;
  logic               w_cmp_pass;

  hash_cmp_serial #(
    .HASH_W(HASH_W)
  ) u_cmp (
    .clk       (clock),
    .rst_n     (reset),
    .i_tgt_load(w_accept),
    .i_target  (target),
    .i_load    (w_cmp_load),
    .i_hash    (HASH),
    .i_step    (w_cmp_step),
    .o_hash    (w_cap_hash),
    .o_done_c  (w_cmp_done),
    .o_pass_c  (w_cmp_pass)
  );

  // Try counter saturates so an unlimited search never wraps it.
  assign w_tries_inc = (r_tries == '1) ? r_tries : r_tries + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_nonce_nxt  = r_nonce;
    w_tries_nxt  = r_tries;
    w_gnonce_nxt = r_gnonce;
    w_ghash_nxt  = r_ghash;
    w_found_nxt  = r_found;
    w_exh_nxt    = r_exh;
    w_accept     = 1'b0;
    w_cmp_load   = 1'b0;
    w_cmp_step   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_nxt  = ST_REQ;
          w_nonce_nxt  = nonce_base;
          w_tries_nxt  = '0;
          w_gnonce_nxt = '0;
          w_ghash_nxt  = '0;
          w_found_nxt  = 1'b0;
          w_exh_nxt    = 1'b0;
        end
      end
      ST_REQ: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (hash_valid) begin
          w_cmp_load  = 1'b1;
          w_state_nxt = ST_CMP;
        end
      end
      ST_CMP: begin
        w_cmp_step = 1'b1;
        if (w_cmp_done) begin
          w_tries_nxt = w_tries_inc;
          if (w_cmp_pass) begin
            w_found_nxt  = 1'b1;
            w_gnonce_nxt = r_nonce;
            w_ghash_nxt  = w_cap_hash;
            w_state_nxt  = ST_DONE;
          end else if ((r_max != '0) && (w_tries_inc == r_max)) begin
            w_exh_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_nonce_nxt = r_nonce + 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_nonce   <= '0;
      r_tries   <= '0;
      r_max     <= '0;
      r_gnonce  <= '0;
      r_ghash   <= '0;
      r_found   <= 1'b0;
      r_exh     <= 1'b0;
      r_run_req <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_nonce   <= w_nonce_nxt;
      r_tries   <= w_tries_nxt;
      r_gnonce  <= w_gnonce_nxt;
      r_ghash   <= w_ghash_nxt;
      r_found   <= w_found_nxt;
      r_exh     <= w_exh_nxt;
      r_run_req <= (w_state_nxt == ST_REQ);
      r_busy    <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT) ||
                   (w_state_nxt == ST_CMP);
      if (w_accept) begin
        r_max <= max_tries;
      end
    end
  end

  assign nonce        = r_nonce;
  assign run_req      = r_run_req;
  assign busy         = r_busy;
  assign found        = r_found;
  assign exhausted    = r_exh;
  assign golden_nonce = r_gnonce;
  assign golden_hash  = r_ghash;
  assign tries        = r_tries;

endmodule
